pipeline_trace_unit: RTL and testbench

Synthesizable, parametrised in-flight instruction tracker. It mirrors the CPU pipeline's per-stage occupancy using the same stall and flush controls the pipeline uses. It records each instruction's PC, residency latency and stall cycles, and emits one retire record per completed instruction. It sits beside the pipeline in the Phase-2 core and feeds the trace/debug path and the testbench scoreboard.

---
 rtl/pipeline_trace_unit.sv | 124 ++++++++++++
 tb/tb_pipeline_trace_unit.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_trace_unit.sv
// In-flight instruction tracker: shadows pipeline stage occupancy under the core's
// stall/flush controls and emits one retire record per completed instruction.
module pipeline_trace_unit #(
  parameter int NUM_STAGES = 5,
  parameter int PC_W       = 16,
  parameter int CNT_W      = 8,
  parameter int CYC_W      = 32
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              fetch_valid,
  input  logic [PC_W-1:0]                   fetch_pc,
  input  logic [NUM_STAGES-1:0]             stall,
  input  logic [NUM_STAGES-1:0]             flush,
  output logic                              retire_valid,
  output logic [PC_W-1:0]                   retire_pc,
  output logic [CNT_W-1:0]                  retire_latency,
  output logic [CNT_W-1:0]                  retire_stall_cycles,
  output logic [CYC_W-1:0]                  retire_cycle,
  output logic [CYC_W-1:0]                  cycle_count,
  output logic [CYC_W-1:0]                  retired_count,
  output logic [CYC_W-1:0]                  squashed_count,
  output logic [$clog2(NUM_STAGES+1)-1:0]   occupancy
);

  localparam int OCC_W = $clog2(NUM_STAGES + 1);
  localparam int LAST  = NUM_STAGES - 1;

  logic [NUM_STAGES-1:0] vld;
  logic [NUM_STAGES-1:0] hold;
  logic [NUM_STAGES-1:0] kill;
  logic [NUM_STAGES-1:0] killed;
  logic [PC_W-1:0]       pc  [NUM_STAGES];
  logic [CNT_W-1:0]      age [NUM_STAGES];
  logic [CNT_W-1:0]      stl [NUM_STAGES];
  logic                  retire_fire;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] x);
    return (x == {CNT_W{1'b1}}) ? x : x + CNT_W'(1);
  endfunction

  function automatic logic [CYC_W-1:0] popcnt(input logic [NUM_STAGES-1:0] v);
    logic [CYC_W-1:0] n;
    n = '0;
    for (int i = 0; i < NUM_STAGES; i++) n = n + CYC_W'(v[i]);
    return n;
  endfunction

  // A stall or flush at stage k reaches every younger stage 0..k.
  always_comb begin
    hold = '0;
    kill = '0;
    for (int j = 0; j < NUM_STAGES; j++) begin
      hold[j] = |(stall >> j);
      kill[j] = |(flush >> j);
    end
  end

  assign retire_fire = vld[LAST] & ~hold[LAST] & ~kill[LAST];
  assign killed      = vld & kill;
  assign occupancy   = OCC_W'(popcnt(vld));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld <= '0;
    end else begin
      if (kill[0])       vld[0] <= 1'b0;
      else if (!hold[0]) vld[0] <= fetch_valid;
      for (int j = 1; j < NUM_STAGES; j++) begin
        if (kill[j] || (!hold[j] && hold[j-1])) vld[j] <= 1'b0;
        else if (!hold[j])                      vld[j] <= vld[j-1];
      end
    end
  end

  // Payload carries no reset; it is only observed while the matching valid is set.
  always_ff @(posedge clk) begin
    if (!hold[0]) begin
      pc[0]  <= fetch_pc;
      age[0] <= CNT_W'(1);
      stl[0] <= '0;
    end else if (vld[0]) begin
      age[0] <= sat_inc(age[0]);
      stl[0] <= sat_inc(stl[0]);
    end
    for (int j = 1; j < NUM_STAGES; j++) begin
      if (hold[j]) begin
        if (vld[j]) begin
          age[j] <= sat_inc(age[j]);
          stl[j] <= sat_inc(stl[j]);
        end
      end else begin
        pc[j]  <= pc[j-1];
        age[j] <= sat_inc(age[j-1]);
        stl[j] <= stl[j-1];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      retire_valid        <= 1'b0;
      retire_pc           <= '0;
      retire_latency      <= '0;
      retire_stall_cycles <= '0;
      retire_cycle        <= '0;
      cycle_count         <= '0;
      retired_count       <= '0;
      squashed_count      <= '0;
    end else begin
      cycle_count    <= cycle_count + CYC_W'(1);
      squashed_count <= squashed_count + popcnt(killed);
      retire_valid   <= retire_fire;
      if (retire_fire) begin
        retire_pc           <= pc[LAST];
        retire_latency      <= age[LAST];
        retire_stall_cycles <= stl[LAST];
        retire_cycle        <= cycle_count;
        retired_count       <= retired_count + CYC_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_pipeline_trace_unit.sv
// Directed bench for pipeline_trace_unit: per-edge vector table plus saturation and reset sequences.
module tb_pipeline_trace_unit;

  localparam int N     = 5;
  localparam int PC_W  = 16;
  localparam int CNT_W = 8;
  localparam int CYC_W = 32;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             fetch_valid = 1'b0;
  logic [PC_W-1:0]  fetch_pc = '0;
  logic [N-1:0]     stall = '0;
  logic [N-1:0]     flush = '0;
  logic             retire_valid;
  logic [PC_W-1:0]  retire_pc;
  logic [CNT_W-1:0] retire_latency;
  logic [CNT_W-1:0] retire_stall_cycles;
  logic [CYC_W-1:0] retire_cycle;
  logic [CYC_W-1:0] cycle_count;
  logic [CYC_W-1:0] retired_count;
  logic [CYC_W-1:0] squashed_count;
  logic [2:0]       occupancy;

  pipeline_trace_unit #(.NUM_STAGES(N), .PC_W(PC_W), .CNT_W(CNT_W), .CYC_W(CYC_W)) dut (
    .clk(clk), .rst(rst), .fetch_valid(fetch_valid), .fetch_pc(fetch_pc),
    .stall(stall), .flush(flush), .retire_valid(retire_valid), .retire_pc(retire_pc),
    .retire_latency(retire_latency), .retire_stall_cycles(retire_stall_cycles),
    .retire_cycle(retire_cycle), .cycle_count(cycle_count), .retired_count(retired_count),
    .squashed_count(squashed_count), .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        fv;
    logic [15:0] pc;
    logic [4:0]  st;
    logic [4:0]  fl;
    logic        rv;
    logic [15:0] rpc;
    logic [7:0]  rlat;
    logic [7:0]  rstl;
    logic [31:0] rcyc;
    logic [2:0]  occ;
    logic [31:0] sq;
  } vec_t;

  vec_t tbl[$];
  int total = 0;
  int bad = 0;
  int unsigned exp_cyc = 0;
  int unsigned exp_ret = 0;

  function automatic vec_t r(input logic fv, input logic [15:0] pc, input logic [4:0] st,
                             input logic [4:0] fl, input logic rv, input logic [15:0] rpc,
                             input logic [7:0] rlat, input logic [7:0] rstl,
                             input logic [31:0] rcyc, input logic [2:0] occ,
                             input logic [31:0] sq);
    vec_t v;
    v.fv = fv; v.pc = pc; v.st = st; v.fl = fl; v.rv = rv; v.rpc = rpc;
    v.rlat = rlat; v.rstl = rstl; v.rcyc = rcyc; v.occ = occ; v.sq = sq;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    exp_cyc++;
  endtask

  task automatic drive(input logic fv, input logic [15:0] pc, input logic [4:0] st,
                       input logic [4:0] fl);
    fetch_valid = fv;
    fetch_pc    = pc;
    stall       = st;
    flush       = fl;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_rv"},   64'(retire_valid), 64'd0);
    chk({tag, "_rpc"},  64'(retire_pc), 64'd0);
    chk({tag, "_rlat"}, 64'(retire_latency), 64'd0);
    chk({tag, "_rstl"}, 64'(retire_stall_cycles), 64'd0);
    chk({tag, "_rcyc"}, 64'(retire_cycle), 64'd0);
    chk({tag, "_cyc"},  64'(cycle_count), 64'd0);
    chk({tag, "_ret"},  64'(retired_count), 64'd0);
    chk({tag, "_sq"},   64'(squashed_count), 64'd0);
    chk({tag, "_occ"},  64'(occupancy), 64'd0);
  endtask

  task automatic apply_row(input vec_t v, input int idx);
    drive(v.fv, v.pc, v.st, v.fl);
    step();
    chk($sformatf("rv[%0d]", idx), 64'(retire_valid), 64'(v.rv));
    if (v.rv) begin
      exp_ret++;
      chk($sformatf("rpc[%0d]", idx),  64'(retire_pc), 64'(v.rpc));
      chk($sformatf("rlat[%0d]", idx), 64'(retire_latency), 64'(v.rlat));
      chk($sformatf("rstl[%0d]", idx), 64'(retire_stall_cycles), 64'(v.rstl));
      chk($sformatf("rcyc[%0d]", idx), 64'(retire_cycle), 64'(v.rcyc));
    end
    chk($sformatf("occ[%0d]", idx), 64'(occupancy), 64'(v.occ));
    chk($sformatf("sq[%0d]", idx),  64'(squashed_count), 64'(v.sq));
    chk($sformatf("ret[%0d]", idx), 64'(retired_count), 64'(exp_ret));
    chk($sformatf("cyc[%0d]", idx), 64'(cycle_count), 64'(exp_cyc));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic saw_rv;

    // single instruction, unstalled
    tbl.push_back(r(1, 16'h0010, 0, 0, 0, 0, 0, 0, 0, 1, 0));
    for (int i = 0; i < 4; i++) tbl.push_back(r(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
    tbl.push_back(r(0, 0, 0, 0, 1, 16'h0010, 5, 0, 5, 0, 0));
    // back-to-back stream of three
    tbl.push_back(r(1, 16'h0100, 0, 0, 0, 0, 0, 0, 0, 1, 0));
    tbl.push_back(r(1, 16'h0104, 0, 0, 0, 0, 0, 0, 0, 2, 0));
    tbl.push_back(r(1, 16'h0108, 0, 0, 0, 0, 0, 0, 0, 3, 0));
    tbl.push_back(r(0, 0, 0, 0, 0, 0, 0, 0, 0, 3, 0));
    tbl.push_back(r(0, 0, 0, 0, 0, 0, 0, 0, 0, 3, 0));
    tbl.push_back(r(0, 0, 0, 0, 1, 16'h0100, 5, 0, 11, 2, 0));
    tbl.push_back(r(0, 0, 0, 0, 1, 16'h0104, 5, 0, 12, 1, 0));
    tbl.push_back(r(0, 0, 0, 0, 1, 16'h0108, 5, 0, 13, 0, 0));
    // stall[1] for two cycles with the instruction in stage 1
    tbl.push_back(r(1, 16'h0200, 0, 0, 0, 0, 0, 0, 0, 1, 0));
    tbl.push_back(r(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
    tbl.push_back(r(0, 0, 5'b00010, 0, 0, 0, 0, 0, 0, 1, 0));
    tbl.push_back(r(0, 0, 5'b00010, 0, 0, 0, 0, 0, 0, 1, 0));
    for (int i = 0; i < 3; i++) tbl.push_back(r(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
    tbl.push_back(r(0, 0, 0, 0, 1, 16'h0200, 7, 2, 21, 0, 0));
    // fill all stages, then flush[2]
    for (int i = 0; i < 5; i++)
      tbl.push_back(r(1, 16'(16'h0300 + 4 * i), 0, 0, 0, 0, 0, 0, 0, 3'(i + 1), 0));
    tbl.push_back(r(0, 0, 0, 5'b00100, 1, 16'h0300, 5, 0, 27, 2, 3));
    tbl.push_back(r(0, 0, 0, 0, 1, 16'h0304, 5, 0, 28, 1, 3));
    tbl.push_back(r(0, 0, 0, 0, 1, 16'h0308, 5, 0, 29, 0, 3));
    // fill all stages, then flush[4] with stall[4]
    for (int i = 0; i < 5; i++)
      tbl.push_back(r(1, 16'(16'h0400 + 4 * i), 0, 0, 0, 0, 0, 0, 0, 3'(i + 1), 3));
    tbl.push_back(r(0, 0, 5'b10000, 5'b10000, 0, 0, 0, 0, 0, 0, 8));
    tbl.push_back(r(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 8));

    // reset state
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("init");
    rst = 1'b0;
    exp_cyc = 0;

    foreach (tbl[i]) apply_row(tbl[i], i);

    // counter saturation: stall[4] held 300 cycles, fetch offered meanwhile is ignored
    drive(1, 16'h0500, 0, 0);
    step();
    drive(0, 0, 0, 0);
    repeat (4) step();
    chk("sat_occ_pre", 64'(occupancy), 64'd1);
    drive(1, 16'h0666, 5'b10000, 0);
    saw_rv = 1'b0;
    for (int i = 0; i < 300; i++) begin
      step();
      if (retire_valid) saw_rv = 1'b1;
    end
    chk("sat_no_rv", 64'(saw_rv), 64'd0);
    chk("sat_occ_hold", 64'(occupancy), 64'd1);
    drive(0, 0, 0, 0);
    step();
    chk("sat_rv", 64'(retire_valid), 64'd1);
    chk("sat_rpc", 64'(retire_pc), 64'h0500);
    chk("sat_rlat", 64'(retire_latency), 64'd255);
    chk("sat_rstl", 64'(retire_stall_cycles), 64'd255);
    chk("sat_rcyc", 64'(retire_cycle), 64'd342);
    chk("sat_ret", 64'(retired_count), 64'd9);
    step();
    chk("sat_rv_drop", 64'(retire_valid), 64'd0);
    chk("sat_rpc_hold", 64'(retire_pc), 64'h0500);
    chk("sat_occ_post", 64'(occupancy), 64'd0);

    // asynchronous reset with three stages valid
    for (int i = 0; i < 3; i++) begin
      drive(1, 16'(16'h0700 + 4 * i), 0, 0);
      step();
    end
    drive(0, 0, 0, 0);
    chk("pre_rst_occ", 64'(occupancy), 64'd3);
    chk("pre_rst_cyc", 64'(cycle_count), 64'(exp_cyc));
    #2;
    rst = 1'b1;
    #1;
    check_all_zero("arst");
    step();
    check_all_zero("arst_hold");
    #2;
    rst = 1'b0;
    exp_cyc = 0;
    step();
    chk("post_rst_cyc", 64'(cycle_count), 64'd1);
    chk("post_rst_sq", 64'(squashed_count), 64'd0);
    chk("post_rst_occ", 64'(occupancy), 64'd0);
    chk("post_rst_rv", 64'(retire_valid), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
